// File: rtl/nes_video_pkg.sv
// Shared NES-on-VGA video timing defaults and the scanline scheduler state type.
package nes_video_pkg;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_TOT_DEF    = 523;
  localparam int NMI_LINE_DEF = 482;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_READY = 2'd2
  } sched_state_e;
endpackage

// File: rtl/scanline_edge_detect.sv
// One-cycle line event: DrawX wraps back to 0 from any nonzero value.
module scanline_edge_detect (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [10:0] DrawX,
  output logic        line_ev
);
  logic [10:0] prev_x_q, prev_x_d;

  always_comb prev_x_d = DrawX;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) prev_x_q <= '0;
    else       prev_x_q <= prev_x_d;
  end

  assign line_ev = (DrawX == 11'd0) && (prev_x_q != 11'd0);
endmodule

// File: rtl/scanline_scheduler.sv
// Schedules PPU line renders against VGA scan-out: each NES line is shown on two
// VGA lines, banks swap on even lines, and a late PPU is flagged as an overrun.
module scanline_scheduler
  import nes_video_pkg::*;
#(
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_TOT    = V_TOT_DEF,
  parameter int NMI_LINE = NMI_LINE_DEF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [10:0] DrawX,
  input  logic [10:0] DrawY,
  input  logic        frame_en,
  input  logic        ppu_line_done,
  output logic        ppu_line_start,
  output logic [7:0]  ppu_line_num,
  output logic        wr_bank,
  output logic        rd_bank,
  output logic        nmi_pulse,
  output logic        overrun,
  output logic [7:0]  overrun_cnt,
  output logic        busy
);
  localparam logic [10:0] VA    = 11'(V_ACTIVE);
  localparam logic [10:0] VA_M2 = 11'(V_ACTIVE - 2);
  localparam logic [10:0] VT    = 11'(V_TOT);
  localparam logic [10:0] NMI_Y = 11'(NMI_LINE);

  sched_state_e state_q, state_d;
  logic       wr_bank_q, wr_bank_d;
  logic [7:0] num_q, num_d;
  logic [7:0] cnt_q, cnt_d;
  logic       start_q, start_d;
  logic       ovr_q, ovr_d;
  logic       nmi_q, nmi_d;
  logic       line_ev, in_time, swap_line;

  scanline_edge_detect u_edge (
    .Clk     (Clk),
    .Reset   (Reset),
    .DrawX   (DrawX),
    .line_ev (line_ev)
  );

  always_comb begin
    state_d   = state_q;
    wr_bank_d = wr_bank_q;
    num_d     = num_q;
    cnt_d     = cnt_q;
    start_d   = 1'b0;
    ovr_d     = 1'b0;
    nmi_d     = line_ev && (DrawY == NMI_Y);
    // A done arriving on the swap cycle itself still counts as in time.
    in_time   = (state_q == ST_READY) || ((state_q == ST_BUSY) && ppu_line_done);
    swap_line = !DrawY[0] && (DrawY < VA);

    if ((state_q == ST_BUSY) && ppu_line_done) state_d = ST_READY;

    if (line_ev) begin
      if ((DrawY == VT) && frame_en) begin
        start_d = 1'b1;
        num_d   = 8'd0;
        state_d = ST_BUSY;
      end else begin
        if (swap_line) begin
          if (in_time) begin
            wr_bank_d = ~wr_bank_q;
          end else if (state_q == ST_BUSY) begin
            ovr_d = 1'b1;
            if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
          end
          if ((DrawY < VA_M2) && frame_en && (state_q != ST_IDLE)) begin
            start_d = 1'b1;
            num_d   = DrawY[8:1] + 8'd1;
            state_d = ST_BUSY;
          end else if (DrawY == VA_M2) begin
            state_d = ST_IDLE;
          end
        end
        if (!frame_en) state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      wr_bank_q <= 1'b0;
      num_q     <= '0;
      cnt_q     <= '0;
      start_q   <= 1'b0;
      ovr_q     <= 1'b0;
      nmi_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_bank_q <= wr_bank_d;
      num_q     <= num_d;
      cnt_q     <= cnt_d;
      start_q   <= start_d;
      ovr_q     <= ovr_d;
      nmi_q     <= nmi_d;
    end
  end

  assign ppu_line_start = start_q;
  assign ppu_line_num   = num_q;
  assign wr_bank        = wr_bank_q;
  assign rd_bank        = ~wr_bank_q;
  assign nmi_pulse      = nmi_q;
  assign overrun        = ovr_q;
  assign overrun_cnt    = cnt_q;
  assign busy           = (state_q == ST_BUSY);
endmodule

// File: tb/tb_scanline_scheduler.sv
// Randomized bench for scanline_scheduler with a render-tracking reference model.
module tb_scanline_scheduler;
  localparam int V_ACTIVE = 480;
  localparam int V_TOT    = 523;
  localparam int NMI      = 482;
  localparam int H        = 8;
  localparam int NONE     = 4095;
  localparam int M_MAN = 0, M_FAST = 1, M_MIX = 2, M_NEVER = 3;

  logic        Clk = 1'b0;
  logic        Reset, frame_en, ppu_line_done;
  logic [10:0] DrawX, DrawY;
  logic        ppu_line_start, wr_bank, rd_bank, nmi_pulse, overrun, busy;
  logic [7:0]  ppu_line_num, overrun_cnt;

  scanline_scheduler dut (
    .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
    .frame_en(frame_en), .ppu_line_done(ppu_line_done),
    .ppu_line_start(ppu_line_start), .ppu_line_num(ppu_line_num),
    .wr_bank(wr_bank), .rd_bank(rd_bank), .nmi_pulse(nmi_pulse),
    .overrun(overrun), .overrun_cnt(overrun_cnt), .busy(busy)
  );

  always #5 Clk = ~Clk;

  int total = 0, bad = 0;
  int mode = M_MAN, cd = 0, fx = NONE, fy = NONE;
  bit rst_next = 1'b1, fe_next = 1'b1;

  // Reference model: is the scheduler running this frame, and is a render outstanding.
  int m_prevx = 0;
  bit m_active = 0, m_inflight = 0;
  bit e_start = 0, e_ovr = 0, e_nmi = 0, e_wr = 0;
  int e_num = 0, e_cnt = 0;

  int n_start = 0, n_swap = 0, n_nmi = 0, n_ovr = 0;
  int p_start, p_swap, p_nmi, p_ovr, s_start = 0, s_swap = 0, s_nmi = 0, s_ovr = 0;
  logic prev_wr = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prevx = 0; m_active = 0; m_inflight = 0;
    e_start = 0; e_ovr = 0; e_nmi = 0; e_wr = 0; e_num = 0; e_cnt = 0;
  endtask

  // Effect of the inputs just driven, as seen after the coming clock edge.
  task automatic model_step();
    bit ev, in_time;
    if (Reset) begin model_reset(); return; end
    ev = (DrawX == 0) && (m_prevx != 0);
    m_prevx = int'(DrawX);
    e_start = 0; e_ovr = 0;
    e_nmi = ev && (DrawY == NMI);
    in_time = m_active && (!m_inflight || ppu_line_done);
    if (ppu_line_done) m_inflight = 0;
    if (ev) begin
      if (DrawY == V_TOT && frame_en) begin
        e_start = 1; e_num = 0; m_active = 1; m_inflight = 1;
      end else begin
        if (DrawY % 2 == 0 && DrawY < V_ACTIVE) begin
          if (in_time) e_wr = !e_wr;
          else if (m_active) begin e_ovr = 1; e_cnt = (e_cnt < 255) ? e_cnt + 1 : 255; end
          if (frame_en && m_active && DrawY < V_ACTIVE - 2) begin
            e_start = 1; e_num = int'(DrawY) / 2 + 1; m_inflight = 1;
          end
          if (DrawY == V_ACTIVE - 2) m_active = 0;
        end
        if (!frame_en) m_active = 0;
      end
    end
    if (!m_active) m_inflight = 0;
  endtask

  task automatic compare();
    check("start", ppu_line_start, e_start);
    check("num", ppu_line_num, e_num);
    check("wr_bank", wr_bank, e_wr);
    check("rd_bank", rd_bank, !e_wr);
    check("nmi", nmi_pulse, e_nmi);
    check("overrun", overrun, e_ovr);
    check("overrun_cnt", overrun_cnt, e_cnt);
    check("busy", busy, m_inflight);
    if (ppu_line_start === 1'b1) n_start++;
    if (nmi_pulse === 1'b1) n_nmi++;
    if (overrun === 1'b1) n_ovr++;
    if (wr_bank !== prev_wr) n_swap++;
    prev_wr = wr_bank;
  endtask

  // One clock: check outputs, drive next inputs (PPU responder included), advance model.
  task automatic step(input int x, input int y);
    @(negedge Clk);
    compare();
    Reset = rst_next;
    frame_en = fe_next;
    DrawX = 11'(x);
    DrawY = 11'(y);
    ppu_line_done = 1'b0;
    if (ppu_line_start === 1'b1) begin
      case (mode)
        M_FAST:  cd = int'($urandom_range(1, 7));
        M_MIX:   cd = int'($urandom_range(1, 20));
        default: cd = 0;
      endcase
    end else if (cd > 0) begin
      cd--;
      if (cd == 0) ppu_line_done = 1'b1;
    end
    if (x == fx && y == fy) ppu_line_done = 1'b1;
    model_step();
  endtask

  task automatic snap();
    p_start = s_start; p_swap = s_swap; p_nmi = s_nmi; p_ovr = s_ovr;
    s_start = n_start; s_swap = n_swap; s_nmi = n_nmi; s_ovr = n_ovr;
  endtask

  task automatic run_line(input int y);
    if (mode == M_MIX && $urandom_range(0, 15) == 0) fe_next = !fe_next;
    for (int x = 0; x < H; x++) begin
      step(x, y);
      if (x == 1 && y == NMI) check("nmi_at_482", nmi_pulse, 1);
      if (x == 4 && y == 480) check("idle_after_478", busy, 0);
      if (x == 4 && y == 522) snap();
    end
  endtask

  task automatic run_lines(input int a, input int b);
    for (int y = a; y <= b; y++) run_line(y);
  endtask

  task automatic frame();
    run_line(V_TOT);
    run_lines(0, V_TOT - 1);
  endtask

  initial begin
    int s, t0, r0;
    Reset = 1'b1; frame_en = 1'b1; ppu_line_done = 1'b0; DrawX = '0; DrawY = '0;
    repeat (3) step(0, 0);
    check("rst_wr_bank", wr_bank, 0);
    check("rst_busy", busy, 0);
    check("rst_cnt", overrun_cnt, 0);
    check("rst_num", ppu_line_num, 0);

    // Directed: first frame start, swaps, overrun, coincident done.
    rst_next = 1'b0;
    run_lines(518, 522);
    step(0, V_TOT); step(1, V_TOT);
    check("vtot_start", ppu_line_start, 1);
    check("vtot_num", ppu_line_num, 0);
    check("vtot_busy", busy, 1);
    fy = V_TOT; fx = 5;
    for (int x = 2; x < H; x++) step(x, V_TOT);
    step(0, 0); step(1, 0);
    check("l0_wr_bank", wr_bank, 1);
    check("l0_start", ppu_line_start, 1);
    check("l0_num", ppu_line_num, 1);
    for (int x = 2; x < H; x++) step(x, 0);
    s = n_start;
    run_line(1);
    check("odd_no_start", n_start - s, 0);
    step(0, 2); step(1, 2);
    check("l2_overrun", overrun, 1);
    check("l2_cnt", overrun_cnt, 1);
    check("l2_wr_bank", wr_bank, 1);
    check("l2_start", ppu_line_start, 1);
    check("l2_num", ppu_line_num, 2);
    for (int x = 2; x < H; x++) step(x, 2);
    run_line(3);
    fy = 4; fx = 0;
    step(0, 4); step(1, 4);
    check("l4_wr_bank", wr_bank, 0);
    check("l4_overrun", overrun, 0);
    check("l4_cnt", overrun_cnt, 1);
    check("l4_num", ppu_line_num, 3);
    for (int x = 2; x < H; x++) step(x, 4);
    fx = NONE; fy = NONE;
    mode = M_FAST;
    run_lines(5, V_TOT - 1);

    // Full on-time frame.
    frame();
    check("frame_starts", s_start - p_start, 240);
    check("frame_swaps", s_swap - p_swap, 240);
    check("frame_nmi", s_nmi - p_nmi, 1);
    check("frame_overruns", s_ovr - p_ovr, 0);

    // Random PPU latency and frame_en toggling.
    mode = M_MIX;
    frame();
    frame();

    // PPU never finishes: saturate the overrun counter.
    fe_next = 1'b1; mode = M_NEVER;
    t0 = s_ovr;
    frame();
    frame();
    check("sat_overruns", s_ovr - t0, 480);
    check("sat_cnt", overrun_cnt, 255);

    // Reset in the middle of a render.
    mode = M_FAST;
    run_line(V_TOT);
    run_lines(0, 99);
    mode = M_NEVER;
    for (int x = 0; x < 4; x++) step(x, 100);
    check("busy_pre_rst", busy, 1);
    Reset = 1'b1; rst_next = 1'b1;
    model_reset();
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_wr_bank", wr_bank, 0);
    check("midrst_num", ppu_line_num, 0);
    check("midrst_cnt", overrun_cnt, 0);
    r0 = n_start;
    step(4, 100); step(5, 100);
    rst_next = 1'b0; mode = M_FAST;
    step(6, 100); step(7, 100);
    run_lines(101, V_TOT - 1);
    check("no_start_after_rst", s_start - r0, 0);
    step(0, V_TOT); step(1, V_TOT);
    check("restart_start", ppu_line_start, 1);
    check("restart_num", ppu_line_num, 0);
    check("restart_busy", busy, 1);
    step(2, V_TOT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
